irq_pending_latch: RTL and testbench

- Upstream stage for the 8-to-3 priority encoder.
- Turns 8 level request lines into sticky, maskable pending bits.
- Presents the masked pending vector to the encoder's 8-bit x input.
- Clears a bit when the consumer acknowledges the index the encoder produced; counts events lost to re-triggering while a bit is already pending.

---
 rtl/irq_pending_latch.sv | 78 +++++++
 tb/tb_irq_pending_latch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Sticky, maskable interrupt pending latch feeding an 8-to-3 priority encoder.
// Rising edges set pending bits; acks to the encoder's index clear them; re-triggers on pending lines are counted.
module irq_pending_latch #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    irq_in,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    pend_o,
  output logic            valid_o,
  input  logic            ack_i,
  input  logic [IDXW-1:0] ack_idx_i,
  output logic            ack_err_o,
  output logic [N-1:0]    pending_raw_o,
  output logic [CNTW-1:0] lost_cnt_o,
  input  logic            lost_clr_i
);

  logic [N-1:0]    irq_d;
  logic [N-1:0]    pending;
  logic [CNTW-1:0] lost_cnt;

  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic [N-1:0]    loss;
  logic            ack_bad;
  logic [CNTW:0]   loss_pop;
  logic [CNTW:0]   cnt_sum;
  logic [CNTW-1:0] cnt_next;

  assign rise          = irq_in & ~irq_d;
  assign pend_o        = pending & mask;
  assign valid_o       = |pend_o;
  assign pending_raw_o = pending;
  assign lost_cnt_o    = lost_cnt;

  // An ack only counts against a line that is both pending and unmasked.
  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      clr[i] = ack_i && (ack_idx_i == IDXW'(i)) && pend_o[i];
    end
  end

  assign ack_bad = ack_i && !(|clr);
  assign loss    = rise & pending & ~clr;

  always_comb begin
    loss_pop = '0;
    for (int unsigned i = 0; i < N; i++) begin
      loss_pop = loss_pop + (CNTW+1)'(loss[i]);
    end
  end

  // One spare bit holds the carry; any carry means the count would pass all-ones.
  always_comb begin
    cnt_sum  = (lost_clr_i ? '0 : {1'b0, lost_cnt}) + loss_pop;
    cnt_next = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_d     <= '0;
      pending   <= '0;
      lost_cnt  <= '0;
      ack_err_o <= 1'b0;
    end else begin
      irq_d     <= irq_in;
      pending   <= (pending & ~clr) | rise;
      lost_cnt  <= cnt_next;
      ack_err_o <= ack_bad;
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed scenarios plus randomized traffic against a per-line behavioural model.
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] pend_o;
  logic       valid_o;
  logic       ack_i;
  logic [2:0] ack_idx_i;
  logic       ack_err_o;
  logic [7:0] pending_raw_o;
  logic [7:0] lost_cnt_o;
  logic       lost_clr_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  bit [7:0] m_pend = '0;
  bit [7:0] m_prev = '0;
  int       m_lost = 0;
  bit       m_err  = 1'b0;

  irq_pending_latch #(.N(8), .IDXW(3), .CNTW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .mask         (mask),
    .pend_o       (pend_o),
    .valid_o      (valid_o),
    .ack_i        (ack_i),
    .ack_idx_i    (ack_idx_i),
    .ack_err_o    (ack_err_o),
    .pending_raw_o(pending_raw_o),
    .lost_cnt_o   (lost_cnt_o),
    .lost_clr_i   (lost_clr_i)
  );

  always #5 clk = ~clk;

  // Advance one clock: compute the model's next state from the inputs, then commit after the edge.
  task automatic tick();
    bit [7:0] np, nprev;
    int       nl, losses;
    bit       ne, hit;
    if (rst) begin
      np = '0; nprev = '0; nl = 0; ne = 1'b0;
    end else begin
      hit    = ack_i && m_pend[ack_idx_i] && mask[ack_idx_i];
      ne     = ack_i && !hit;
      np     = m_pend;
      losses = 0;
      if (hit) np[ack_idx_i] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (irq_in[i] && !m_prev[i]) begin
          if (np[i]) losses++;
          np[i] = 1'b1;
        end
      end
      nl = (lost_clr_i ? 0 : m_lost) + losses;
      if (nl > 255) nl = 255;
      nprev = irq_in;
    end
    @(posedge clk);
    #1;
    m_pend = np; m_prev = nprev; m_lost = nl; m_err = ne;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = 8'h81; mask = 8'hFF; ack_i = 1'b0; ack_idx_i = '0; lost_clr_i = 1'b0;
    tick(); tick();
    tests_run++; if (pend_o !== 8'h00) begin tests_failed++; $display("FAIL reset_pend got %h exp 00", pend_o); end
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    tests_run++; if (pending_raw_o !== 8'h00) begin tests_failed++; $display("FAIL reset_raw got %h exp 00", pending_raw_o); end
    tests_run++; if (lost_cnt_o !== 8'h00) begin tests_failed++; $display("FAIL reset_lost got %h exp 00", lost_cnt_o); end
    tests_run++; if (ack_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b exp 0", ack_err_o); end
    rst = 1'b0;
    tick();
    tests_run++; if (pend_o !== 8'h81) begin tests_failed++; $display("FAIL release_pend got %h exp 81", pend_o); end
    tests_run++; if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL release_valid got %b exp 1", valid_o); end
    repeat (3) tick();
    tests_run++; if (pend_o !== 8'h81) begin tests_failed++; $display("FAIL held_pend got %h exp 81", pend_o); end
    tests_run++; if (lost_cnt_o !== 8'h00) begin tests_failed++; $display("FAIL held_lost got %h exp 00", lost_cnt_o); end
    irq_in = 8'h00; ack_i = 1'b1; ack_idx_i = 3'd7; tick();
    ack_idx_i = 3'd0; tick();
    ack_i = 1'b0;
    tests_run++; if (pend_o !== 8'h00) begin tests_failed++; $display("FAIL reset_cleanup got %h exp 00", pend_o); end
  endtask

  task automatic test_ack();
    irq_in = 8'h20; tick();
    irq_in = 8'h00; tick(); tick();
    tests_run++; if (pend_o !== 8'h20) begin tests_failed++; $display("FAIL ack_persist got %h exp 20", pend_o); end
    ack_i = 1'b1; ack_idx_i = 3'd5; tick();
    ack_i = 1'b0;
    tests_run++; if (pend_o !== 8'h00) begin tests_failed++; $display("FAIL ack_clear got %h exp 00", pend_o); end
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL ack_valid got %b exp 0", valid_o); end
    tests_run++; if (ack_err_o !== 1'b0) begin tests_failed++; $display("FAIL ack_noerr got %b exp 0", ack_err_o); end
  endtask

  task automatic test_mask();
    irq_in = 8'h10; tick();
    irq_in = 8'h00; mask = 8'h00; tick();
    tests_run++; if (pend_o !== 8'h00) begin tests_failed++; $display("FAIL mask_hide got %h exp 00", pend_o); end
    tests_run++; if (pending_raw_o !== 8'h10) begin tests_failed++; $display("FAIL mask_raw got %h exp 10", pending_raw_o); end
    ack_i = 1'b1; ack_idx_i = 3'd4; tick();
    ack_i = 1'b0;
    tests_run++; if (ack_err_o !== 1'b1) begin tests_failed++; $display("FAIL mask_ackerr got %b exp 1", ack_err_o); end
    tests_run++; if (pending_raw_o !== 8'h10) begin tests_failed++; $display("FAIL mask_keep got %h exp 10", pending_raw_o); end
    tick();
    tests_run++; if (ack_err_o !== 1'b0) begin tests_failed++; $display("FAIL mask_errpulse got %b exp 0", ack_err_o); end
    mask = 8'hFF; #1;
    tests_run++; if (pend_o !== 8'h10) begin tests_failed++; $display("FAIL unmask_same_cycle got %h exp 10", pend_o); end
    ack_i = 1'b1; tick();
    ack_i = 1'b0;
  endtask

  task automatic test_lost();
    irq_in = 8'h04; tick();
    repeat (2) begin irq_in = 8'h00; tick(); irq_in = 8'h04; tick(); end
    tests_run++; if (lost_cnt_o !== 8'd2) begin tests_failed++; $display("FAIL lost_two got %0d exp 2", lost_cnt_o); end
    irq_in = 8'h00; tick();
    irq_in = 8'h04; ack_i = 1'b1; ack_idx_i = 3'd2; tick();
    ack_i = 1'b0;
    tests_run++; if (pending_raw_o[2] !== 1'b1) begin tests_failed++; $display("FAIL lost_coincide_pend got %b exp 1", pending_raw_o[2]); end
    tests_run++; if (lost_cnt_o !== 8'd2) begin tests_failed++; $display("FAIL lost_coincide_cnt got %0d exp 2", lost_cnt_o); end
    tests_run++; if (ack_err_o !== 1'b0) begin tests_failed++; $display("FAIL lost_coincide_err got %b exp 0", ack_err_o); end
    irq_in = 8'h00; ack_i = 1'b1; tick();
    ack_i = 1'b0; lost_clr_i = 1'b1; tick();
    lost_clr_i = 1'b0;
    tests_run++; if (lost_cnt_o !== 8'd0) begin tests_failed++; $display("FAIL lost_clear got %0d exp 0", lost_cnt_o); end
  endtask

  task automatic test_saturate();
    irq_in = 8'h01; tick();
    for (int i = 0; i < 300; i++) begin irq_in = 8'h00; tick(); irq_in = 8'h01; tick(); end
    tests_run++; if (lost_cnt_o !== 8'd255) begin tests_failed++; $display("FAIL sat_cnt got %0d exp 255", lost_cnt_o); end
    irq_in = 8'h80; tick();
    irq_in = 8'h00; tick();
    tests_run++; if (lost_cnt_o !== 8'd255) begin tests_failed++; $display("FAIL sat_hold got %0d exp 255", lost_cnt_o); end
    irq_in = 8'h81; lost_clr_i = 1'b1; tick();
    lost_clr_i = 1'b0;
    tests_run++; if (lost_cnt_o !== 8'd2) begin tests_failed++; $display("FAIL clr_with_loss got %0d exp 2", lost_cnt_o); end
  endtask

  task automatic test_reset_mid();
    irq_in = 8'hFF; tick();
    tests_run++; if (pend_o !== 8'hFF) begin tests_failed++; $display("FAIL mid_setup got %h exp ff", pend_o); end
    rst = 1'b1; ack_i = 1'b1; ack_idx_i = 3'd3; tick();
    rst = 1'b0; ack_i = 1'b0;
    tests_run++; if (pend_o !== 8'h00) begin tests_failed++; $display("FAIL mid_pend got %h exp 00", pend_o); end
    tests_run++; if (lost_cnt_o !== 8'd0) begin tests_failed++; $display("FAIL mid_lost got %0d exp 0", lost_cnt_o); end
    tests_run++; if (ack_err_o !== 1'b0) begin tests_failed++; $display("FAIL mid_err got %b exp 0", ack_err_o); end
    tick();
    tests_run++; if (pend_o !== 8'hFF) begin tests_failed++; $display("FAIL mid_rearm got %h exp ff", pend_o); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      irq_in     = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      ack_i      = ($urandom_range(0, 2) == 0);
      ack_idx_i  = 3'($urandom);
      if (ack_i && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 8; i++) if (m_pend[i] && mask[i]) ack_idx_i = 3'(i);
      end
      lost_clr_i = ($urandom_range(0, 63) == 0);
      tick();
      tests_run++;
      if (pend_o !== (m_pend & mask) || valid_o !== |(m_pend & mask) || pending_raw_o !== m_pend ||
          ack_err_o !== m_err || lost_cnt_o !== 8'(m_lost)) begin
        tests_failed++;
        if (errs < 10) $display("FAIL rand_cycle%0d got pend=%h v=%b raw=%h err=%b lost=%0d exp pend=%h v=%b raw=%h err=%b lost=%0d",
          c, pend_o, valid_o, pending_raw_o, ack_err_o, lost_cnt_o,
          m_pend & mask, |(m_pend & mask), m_pend, m_err, m_lost);
        errs++;
      end
    end
    rst = 1'b0; ack_i = 1'b0; lost_clr_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ack();
    test_mask();
    test_lost();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
